fft_input_buffer: RTL and testbench
===================================

Name: fft_input_buffer

Overview:
Ping-pong sample buffer between the audio sample source and fft_controller.
- Collects FFT_POINTS streaming samples into one bank while fft_controller reads the other bank.
- Issues a one-cycle data-ready pulse per complete frame.
- Holds the read bank stable until the controller reports completion.
- Flags overruns when the source outpaces the FFT.

Parameters:
DATA_WIDTH, 24, sample width in bits (matches fft_controller DATA_WIDTH)
FFT_POINTS, 512, samples per frame; power of two, minimum 4
LOG2_FFT_POINTS, 9, address width; must equal log2(FFT_POINTS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_sample  input  DATA_WIDTH  incoming audio sample
i_sample_valid  input  1  i_sample is valid this cycle
i_read_addr  input  LOG2_FFT_POINTS  read address from fft_controller (o_buffer_read_addr)
o_read_data  output  DATA_WIDTH  read-bank data, combinational from i_read_addr
o_data_ready  output  1  one-cycle pulse: new frame available (drives fft_controller i_data_ready)
i_fft_done  input  1  pulse from fft_controller o_fft_done; releases the read bank
o_fill_level  output  LOG2_FFT_POINTS+1  samples currently held in the write bank
o_overrun  output  1  sticky: at least one sample was dropped
i_clear_overrun  input  1  clears o_overrun

Behaviour:
Reset (sync, active-high):
- Write pointer = 0; write bank select = 0; read bank = 1.
- read_locked = 0; state = FILL.
- o_data_ready = 0; o_overrun = 0; o_fill_level = 0.
- Bank contents are not reset.

Read port:
- o_read_data = bank[read_sel][i_read_addr], combinational, with no latency.

States:
- FILL: each cycle with i_sample_valid=1, write i_sample to bank[wr_sel][wr_ptr] and increment wr_ptr.
  - On the write of sample FFT_POINTS-1 with read_locked=0: swap banks and set wr_ptr=0 at the same edge. Set read_locked=1. o_data_ready is high for exactly the next cycle. Stay in FILL.
  - On the same write with read_locked=1: go to FULL_WAIT. wr_ptr remains FFT_POINTS and o_fill_level reads FFT_POINTS.
- FULL_WAIT:
  - i_sample_valid=1: sample is dropped and o_overrun is set. Bank contents are untouched.
  - i_fft_done=1: swap, wr_ptr=0, read_locked stays 1, pulse o_data_ready next cycle, then go to FILL. A sample valid in that same cycle is dropped and counts as an overrun.

Lock release:
- In FILL, i_fft_done=1 clears read_locked.
- If i_fft_done and the final-sample write occur in the same cycle, done takes priority: swap immediately, read_locked stays 1, and o_data_ready pulses. No FULL_WAIT.
- i_fft_done while read_locked=0 is ignored.

Overrun flag:
- i_clear_overrun clears o_overrun.
- If clear and a new overrun occur in the same cycle, the set wins.

Reset mid-frame:
- Partial frame is discarded and the lock is released.
- No o_data_ready pulse is generated by reset.

Handshake assumptions:
- o_data_ready never pulses on two consecutive cycles.
- There are at least FFT_POINTS cycles between pulses when i_sample_valid is continuously high.

Optional Feature:
FFT_INPUT_DC_REMOVE_EN
- Defined: each frame, accumulate the signed sum of written samples (DATA_WIDTH+LOG2_FFT_POINTS bits). At swap, latch mean = sum >>> LOG2_FFT_POINTS (arithmetic shift).
  - o_read_data = saturating signed (bank data − latched mean), saturated to DATA_WIDTH.
  - Mean is reset to 0.
  - o_data_ready is delayed by 0 cycles because the mean latches at the swap edge.
- Undefined: no accumulator is built and o_read_data is raw bank data.

Test Plan:
1. Reset, then 512 valid samples with values 1..512 -> o_data_ready high one cycle after the 512th write. With i_read_addr=0 read 1; with i_read_addr=511 read 512. o_fill_level returns to 0.
2. After test 1 with no i_fft_done, feed 512 more samples then 3 extra -> FULL_WAIT, o_fill_level=512, o_overrun=1. i_fft_done pulse -> o_data_ready next cycle and the read bank holds samples 513..1024.
3. Final sample write and i_fft_done in the same cycle -> immediate swap, single o_data_ready pulse, o_overrun stays 0.
4. Assert reset after 200 samples -> o_fill_level=0, no pulse. A following 512 samples yields exactly one pulse.
5. With o_overrun=1, assert i_clear_overrun alone -> 0. Assert it together with a dropped sample -> stays 1.
6. (FFT_INPUT_DC_REMOVE_EN) Frame of constant 1000 -> every read returns 0. Frame alternating +100/−100 -> reads ±100.

Source files
------------

// File: rtl/fft_input_buffer.sv
// ============================================================================
// Module   : fft_input_buffer
// Purpose  : Ping-pong frame buffer feeding fft_controller. Optional
//            mean removal on the read port when FFT_INPUT_DC_REMOVE_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_input_buffer #(
    parameter int DATA_WIDTH      = 24,
    parameter int FFT_POINTS      = 512,
    parameter int LOG2_FFT_POINTS = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      i_sample,
    input  logic                       i_sample_valid,
    input  logic [LOG2_FFT_POINTS-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0]      o_read_data,
    output logic                       o_data_ready,
    input  logic                       i_fft_done,
    output logic [LOG2_FFT_POINTS:0]   o_fill_level,
    output logic                       o_overrun,
    input  logic                       i_clear_overrun
);

    localparam logic [LOG2_FFT_POINTS:0] PTR_LAST = (LOG2_FFT_POINTS+1)'(FFT_POINTS - 1);
    localparam logic [LOG2_FFT_POINTS:0] PTR_FULL = (LOG2_FFT_POINTS+1)'(FFT_POINTS);

    typedef enum logic [0:0] {
        ST_FILL      = 1'b0,
        ST_FULL_WAIT = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [LOG2_FFT_POINTS:0]   wr_ptr_q, wr_ptr_d;
    logic                       wr_sel_q, wr_sel_d;
    logic                       locked_q, locked_d;
    logic                       ready_q, ready_d;
    logic                       overrun_q, overrun_d;

    logic                       wr_en;
    logic                       swap;
    logic                       drop;
    logic [DATA_WIDTH-1:0]      raw_data;

    // Both banks share one array; the bank select is the address MSB.
    logic [DATA_WIDTH-1:0]      mem_q [0:2*FFT_POINTS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_sel_q, wr_ptr_q[LOG2_FFT_POINTS-1:0]}] <= i_sample;
        end
    end

    assign raw_data = mem_q[{~wr_sel_q, i_read_addr}];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_sel_d  = wr_sel_q;
        locked_d  = locked_q;
        wr_en     = 1'b0;
        swap      = 1'b0;
        drop      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (i_fft_done) begin
                    locked_d = 1'b0;
                end
                if (i_sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        // A done arriving with the final sample frees the
                        // read bank just in time, so the swap happens now.
                        if (!locked_q || i_fft_done) begin
                            swap = 1'b1;
                        end else begin
                            state_d  = ST_FULL_WAIT;
                            wr_ptr_d = PTR_FULL;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_FULL_WAIT: begin
                drop = i_sample_valid;
                if (i_fft_done) begin
                    swap    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // The freshly completed frame becomes the read bank and is
        // immediately handed to the controller, so the lock is held.
        if (swap) begin
            wr_sel_d = ~wr_sel_q;
            wr_ptr_d = '0;
            locked_d = 1'b1;
        end

        ready_d   = swap;
        overrun_d = drop ? 1'b1 : (i_clear_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= '0;
            wr_sel_q  <= 1'b0;
            locked_q  <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_sel_q  <= wr_sel_d;
            locked_q  <= locked_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_data_ready = ready_q;
    assign o_fill_level = wr_ptr_q;
    assign o_overrun    = overrun_q;

`ifdef FFT_INPUT_DC_REMOVE_EN
    localparam int SUM_W = DATA_WIDTH + LOG2_FFT_POINTS;

    logic signed [SUM_W-1:0]      sum_q, sum_d, sum_now;
    logic signed [DATA_WIDTH-1:0] mean_q, mean_d;
    logic signed [DATA_WIDTH:0]   diff;

    always_comb begin
        sum_now = sum_q;
        if (wr_en) begin
            sum_now = sum_q + {{LOG2_FFT_POINTS{i_sample[DATA_WIDTH-1]}}, i_sample};
        end
        sum_d  = swap ? '0 : sum_now;
        // Upper DATA_WIDTH bits of the sum are the arithmetic-shifted mean.
        mean_d = swap ? sum_now[SUM_W-1:LOG2_FFT_POINTS] : mean_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            mean_q <= '0;
        end else begin
            sum_q  <= sum_d;
            mean_q <= mean_d;
        end
    end

    always_comb begin
        diff = {raw_data[DATA_WIDTH-1], raw_data} - {mean_q[DATA_WIDTH-1], mean_q};
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
            o_read_data = {diff[DATA_WIDTH], {(DATA_WIDTH-1){~diff[DATA_WIDTH]}}};
        end else begin
            o_read_data = diff[DATA_WIDTH-1:0];
        end
    end
`else
    assign o_read_data = raw_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: directed tables and sequences plus
// randomized traffic against a queue-based frame model.
`default_nettype none

module tb_fft_input_buffer;

    localparam int DW = 24;
    localparam int N  = 512;
    localparam int LG = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] i_sample;
    logic          i_sample_valid;
    logic [LG-1:0] i_read_addr;
    logic [DW-1:0] o_read_data;
    logic          o_data_ready;
    logic          i_fft_done;
    logic [LG:0]   o_fill_level;
    logic          o_overrun;
    logic          i_clear_overrun;

    fft_input_buffer #(.DATA_WIDTH(DW), .FFT_POINTS(N), .LOG2_FFT_POINTS(LG)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .o_data_ready   (o_data_ready),
        .i_fft_done     (i_fft_done),
        .o_fill_level   (o_fill_level),
        .o_overrun      (o_overrun),
        .i_clear_overrun(i_clear_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: a frame is a queue of samples; the controller sees
    // the last published frame.
    logic [DW-1:0] frame_q[$];
    logic [DW-1:0] shown[N];
    bit            shown_valid = 0;
    bit            m_locked, m_pending, m_ovr, m_ready;
    longint        m_mean;

    typedef struct {
        bit            v;
        bit            done;
        bit            clr;
        logic [DW-1:0] s;
        bit            e_rdy;
        int            e_fill;
        bit            e_ovr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint to_signed(input logic [DW-1:0] x);
        longint r = longint'(x);
        if (x[DW-1]) r = r - (longint'(1) << DW);
        return r;
    endfunction

    function automatic logic [63:0] exp_read(input logic [DW-1:0] raw);
`ifdef FFT_INPUT_DC_REMOVE_EN
        longint d = to_signed(raw) - m_mean;
        longint hi = (longint'(1) << (DW-1)) - 1;
        if (d > hi) d = hi;
        if (d < -hi - 1) d = -hi - 1;
        return 64'(d & ((longint'(1) << DW) - 1));
`else
        return 64'(raw);
`endif
    endfunction

    task automatic publish();
        longint sum = 0;
        for (int i = 0; i < N; i++) begin
            shown[i] = frame_q[i];
            sum += to_signed(frame_q[i]);
        end
        m_mean = sum >>> LG;
        frame_q.delete();
        shown_valid = 1;
        m_locked = 1;
        m_ready = 1;
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_locked = 0; m_pending = 0; m_ovr = 0; m_ready = 0; m_mean = 0;
        shown_valid = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] s, input bit done, input bit clr);
        bit set = 0;
        m_ready = 0;
        if (m_pending) begin
            if (v) set = 1;
            if (done) begin
                publish();
                m_pending = 0;
            end
        end else begin
            if (v) frame_q.push_back(s);
            if (frame_q.size() == N) begin
                if (!m_locked || done) publish();
                else m_pending = 1;
            end else if (done) begin
                m_locked = 0;
            end
        end
        m_ovr = set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] s, input bit done, input bit clr);
        int a = $urandom_range(N-1);
        i_sample_valid  = v;
        i_sample        = s;
        i_fft_done      = done;
        i_clear_overrun = clr;
        i_read_addr     = LG'(a);
        @(posedge clk);
        model_step(v, s, done, clr);
        #1;
        if (o_data_ready === 1'b1) pulses++;
        chk("ready", 64'(o_data_ready), 64'(m_ready));
        chk("fill", 64'(o_fill_level), 64'(frame_q.size()));
        chk("overrun", 64'(o_overrun), 64'(m_ovr));
        if (shown_valid) chk("rdata", 64'(o_read_data), exp_read(shown[a]));
        i_sample_valid  = 1'b0;
        i_fft_done      = 1'b0;
        i_clear_overrun = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        i_sample_valid = 0; i_fft_done = 0; i_clear_overrun = 0; i_sample = '0; i_read_addr = '0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        chk("rst_ready", 64'(o_data_ready), 64'd0);
        chk("rst_fill", 64'(o_fill_level), 64'd0);
        chk("rst_overrun", 64'(o_overrun), 64'd0);
    endtask

    task automatic read_chk(input string name, input int a, input logic [DW-1:0] raw);
        i_read_addr = LG'(a);
        #1;
        chk(name, 64'(o_read_data), exp_read(raw));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   base;
        tbl[0] = '{1, 0, 0, 24'd9,  0, N, 1};
        tbl[1] = '{1, 0, 0, 24'd10, 0, N, 1};
        tbl[2] = '{1, 0, 0, 24'd11, 0, N, 1};
        tbl[3] = '{0, 0, 1, 24'd0,  0, N, 0};
        tbl[4] = '{1, 0, 1, 24'd12, 0, N, 1};
        tbl[5] = '{0, 0, 1, 24'd0,  0, N, 0};
        tbl[6] = '{1, 1, 0, 24'd13, 1, 0, 1};
        tbl[7] = '{0, 0, 0, 24'd0,  0, 0, 1};

        do_reset(3);

        // Frame of 1..N with the read bank free.
        for (int i = 1; i <= N; i++) cycle(1, DW'(i), 0, 0);
        chk("t1_ready", 64'(o_data_ready), 64'd1);
        chk("t1_fill", 64'(o_fill_level), 64'd0);
        read_chk("t1_rd0", 0, DW'(1));
        read_chk("t1_rd_last", N-1, DW'(N));
        cycle(0, '0, 0, 0);
        chk("t1_single_pulse", 64'(o_data_ready), 64'd0);

        // Second frame while locked parks in FULL_WAIT.
        for (int i = N+1; i <= 2*N; i++) cycle(1, DW'(i), 0, 0);
        chk("t2_full_fill", 64'(o_fill_level), 64'(N));
        chk("t2_no_ready", 64'(o_data_ready), 64'd0);
        for (int r = 0; r < 8; r++) begin
            cycle(tbl[r].v, tbl[r].s, tbl[r].done, tbl[r].clr);
            chk($sformatf("tbl%0d_ready", r), 64'(o_data_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_fill", r), 64'(o_fill_level), 64'(tbl[r].e_fill));
            chk($sformatf("tbl%0d_ovr", r), 64'(o_overrun), 64'(tbl[r].e_ovr));
        end
        read_chk("t2_rd0", 0, DW'(N+1));
        read_chk("t2_rd_last", N-1, DW'(2*N));

        // Final write coinciding with done: immediate swap, no overrun.
        cycle(0, '0, 0, 1);
        for (int i = 0; i < N-1; i++) cycle(1, DW'(5000 + i), 0, 0);
        cycle(1, DW'(5000 + N - 1), 1, 0);
        chk("t3_ready", 64'(o_data_ready), 64'd1);
        chk("t3_fill", 64'(o_fill_level), 64'd0);
        chk("t3_ovr", 64'(o_overrun), 64'd0);
        cycle(0, '0, 0, 0);
        chk("t3_single_pulse", 64'(o_data_ready), 64'd0);
        cycle(0, '0, 1, 0);

        // Reset mid-frame discards the partial frame and frees the lock.
        for (int i = 0; i < 200; i++) cycle(1, DW'(7000 + i), 0, 0);
        cycle(0, '0, 1, 0);
        do_reset(2);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0);
        base = pulses;
        for (int i = 0; i < N; i++) cycle(1, DW'(9000 + i), 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0);
        chk("t4_pulse_count", 64'(pulses - base), 64'd1);
        read_chk("t4_rd0", 0, DW'(9000));

`ifdef FFT_INPUT_DC_REMOVE_EN
        do_reset(2);
        for (int i = 0; i < N; i++) cycle(1, DW'(1000), 0, 0);
        read_chk("t6_const0", 0, DW'(1000));
        chk("t6_const_zero", 64'(o_read_data), 64'd0);
        cycle(0, '0, 1, 0);
        for (int i = 0; i < N; i++) cycle(1, (i % 2 == 0) ? DW'(100) : DW'(-100), 0, 0);
        read_chk("t6_alt_pos", 0, DW'(100));
        chk("t6_alt_pos_val", 64'(o_read_data), 64'(DW'(100)));
        read_chk("t6_alt_neg", 1, DW'(-100));
        chk("t6_alt_neg_val", 64'(o_read_data), 64'(DW'(-100)));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 300) == 0, ($urandom % 50) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
